vga_sync_monitor: RTL
=====================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: samples incoming active-high hsync/vsync on the pixel clock and recovers pixel position and display-enable.
- Measures line length, lines per frame and sync widths; locks after consecutive consistent frames.
- Used for loopback checking of the VGA output path and as the timing front end for a future capture block.

Parameters:
- HW, 11, width of horizontal counters/measurements
- VW, 10, width of vertical counters/measurements
- H_DE_START, 384, first active h_pos (sync + back porch)
- H_ACTIVE, 1440, active pixels per line
- V_DE_START, 31, first active v_pos
- V_ACTIVE, 900, active lines per frame
- LOCK_FRAMES, 2, consecutive matching frames required for lock (>=1)

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- hsync_in, in, 1, active-high hsync, synchronous to clk unless VGA_SYNC_IN_EN
- vsync_in, in, 1, active-high vsync
- h_pos, out, HW, recovered horizontal position
- v_pos, out, VW, recovered line number
- de, out, 1, display enable aligned with h_pos/v_pos
- frame_start, out, 1, one-cycle pulse when h_pos=0, v_pos=0
- line_len, out, HW, last measured clocks per line
- frame_lines, out, VW, last measured lines per frame
- hs_width, out, HW, last hsync high width in clocks
- vs_width, out, VW, last vsync high width in lines
- locked, out, 1, timing stable
- err, out, 1, one-cycle pulse on timing violation

Behaviour:
- Reset: all outputs, counters, edge registers (hs_d, vs_d) and references = 0; FSM = SEARCH. Async assert clears immediately mid-frame.
- Edges: hs_rise = hsync_in & ~hs_d, vs_rise = vsync_in & ~vs_d. hs_fall/vs_fall analogous.
- Latency: h_pos/v_pos/de/frame_start are registered, one cycle behind the sample (no synchronizer).
- h_pos:
  - on hs_rise, h_pos <= 0 and line_len <= h_pos+1 (1903+1=1904);
  - otherwise h_pos increments, saturating at 2^HW-1 (no wrap).
- v_pos:
  - on vs_rise (coincident with hs_rise), v_pos <= 0 and frame_lines <= v_pos+1;
  - on other hs_rise, v_pos increments, saturating at 2^VW-1.
- hs_width: counts clocks while hsync_in high, latched on hs_fall (152 for nominal timing).
- vs_width: counts hs_rise while vsync_in high, inclusive of the vs_rise line, latched on vs_fall (3 nominal).
- frame_start: registered vs_rise.
- de: locked && H_DE_START <= h_pos <= H_DE_START+H_ACTIVE-1 && V_DE_START <= v_pos <= V_DE_START+V_ACTIVE-1; combinational from registered positions.
- FSM:
  - SEARCH: first vs_rise -> MEASURE.
  - MEASURE: ref_line <= measured length on every hs_rise. Next vs_rise: ref_frame <= measured frame_lines, match_cnt <= 0, frame_bad <= 0, -> CHECK.
  - CHECK:
    - Each hs_rise with measured length != ref_line sets sticky frame_bad.
    - At vs_rise, if !frame_bad and frame length == ref_frame: match_cnt++; when match_cnt reaches LOCK_FRAMES -> LOCKED.
    - Otherwise: err pulse, refs reloaded from current measurement, match_cnt <= 0, frame_bad <= 0, stay in CHECK.
  - LOCKED (locked=1):
    - Any of the following -> err pulse that cycle, locked=0 next cycle, -> SEARCH: hs_rise length mismatch vs ref_line, vs_rise frame mismatch vs ref_frame, h_pos or v_pos reaching saturation.
- Lock timing with defaults: locked rises the cycle after the 4th vs_rise following reset.
- Simultaneous events: vs_rise line check uses the same measured length as the hs_rise check; a single err pulse only.
- Saturation outside LOCKED: no err; the measurement stays clamped until the next edge.

Optional Feature:
- VGA_SYNC_IN_EN defined: 2-flop synchronizer on hsync_in and vsync_in (reset to 0) ahead of edge detection. All outputs delay by 2 extra cycles; measured values are unchanged.
- Not defined: inputs feed edge detection directly and must be synchronous to clk.

Test Plan:
- Nominal 1904x932 timing, hsync 152 clocks, vsync 3 lines, from reset -> line_len=1904, frame_lines=932, hs_width=152, vs_width=3, locked=1 one cycle after 4th vs_rise, err never asserted.
- Locked, full frame -> de high exactly for h_pos 384..1823 and v_pos 31..930; 1,296,000 de cycles per frame; frame_start once per 1,774,528 cycles.
- Locked, one line stretched to 1905 clocks -> err one cycle at that hs_rise, locked=0 next cycle, relock after 4 further vs_rise.
- hsync held low 3000 clocks while locked -> h_pos sticks at 2047, err pulse, locked drops; no wrap to 0.
- rst asserted mid-frame while locked -> all outputs 0 immediately without clock edge; relock after 4 vs_rise post-release.
- Build with VGA_SYNC_IN_EN -> frame_start 2 cycles later than non-synchronized build for the same stimulus; line_len, frame_lines and widths identical.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// vga_sync_monitor
//
// Receive-side counterpart of the VGA timing generator. Samples active-high
// hsync/vsync on the pixel clock, recovers the pixel position and display
// enable, measures line/frame geometry and sync widths, and declares lock
// once LOCK_FRAMES consecutive frames repeat the reference geometry.
//
// Optional build macro:
//   VGA_SYNC_IN_EN - insert a 2-flop synchronizer (reset to 0) on hsync_in
//                    and vsync_in ahead of edge detection. Every output then
//                    lags the pins by two extra clocks; measured values are
//                    unchanged. Without it the sync inputs must already be
//                    synchronous to clk.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   hsync_in     in   active-high horizontal sync
//   vsync_in     in   active-high vertical sync
//   h_pos        out  [HW-1:0] recovered horizontal position (0 at hsync rise)
//   v_pos        out  [VW-1:0] recovered line number (0 at vsync rise)
//   de           out  display enable, aligned with h_pos/v_pos
//   frame_start  out  one-cycle pulse while h_pos=0, v_pos=0
//   line_len     out  [HW-1:0] last measured clocks per line
//   frame_lines  out  [VW-1:0] last measured lines per frame
//   hs_width     out  [HW-1:0] last hsync high width in clocks
//   vs_width     out  [VW-1:0] last vsync high width in lines
//   locked       out  timing stable
//   err          out  one-cycle pulse on a timing violation
// ---------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int H_DE_START  = 384,
  parameter int H_ACTIVE    = 1440,
  parameter int V_DE_START  = 31,
  parameter int V_ACTIVE    = 900,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [HW-1:0] h_pos,
  output logic [VW-1:0] v_pos,
  output logic          de,
  output logic          frame_start,
  output logic [HW-1:0] line_len,
  output logic [VW-1:0] frame_lines,
  output logic [HW-1:0] hs_width,
  output logic [VW-1:0] vs_width,
  output logic          locked,
  output logic          err
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_MAX    = '1;
  localparam logic [VW-1:0] V_MAX    = '1;
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [HW-1:0] H_DE_LO  = HW'(H_DE_START);
  localparam logic [HW-1:0] H_DE_HI  = HW'(H_DE_START + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_DE_LO  = VW'(V_DE_START);
  localparam logic [VW-1:0] V_DE_HI  = VW'(V_DE_START + V_ACTIVE - 1);
  localparam logic [MW-1:0] M_ONE    = MW'(1);
  localparam logic [MW-1:0] LOCK_CNT = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    CHECK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic hs_s;
  logic vs_s;

`ifdef VGA_SYNC_IN_EN
  logic [1:0] hs_sync_reg;
  logic [1:0] vs_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync_reg <= '0;
      vs_sync_reg <= '0;
    end else begin
      hs_sync_reg <= {hs_sync_reg[0], hsync_in};
      vs_sync_reg <= {vs_sync_reg[0], vsync_in};
    end
  end

  assign hs_s = hs_sync_reg[1];
  assign vs_s = vs_sync_reg[1];
`else
  assign hs_s = hsync_in;
  assign vs_s = vsync_in;
`endif

  // -------------------------------------------------------------------------
  // Edge detection
  // -------------------------------------------------------------------------
  logic hs_d;
  logic vs_d;
  logic hs_rise;
  logic hs_fall;
  logic vs_rise;
  logic vs_fall;

  assign hs_rise = hs_s & ~hs_d;
  assign hs_fall = ~hs_s & hs_d;
  assign vs_rise = vs_s & ~vs_d;
  assign vs_fall = ~vs_s & vs_d;

  // -------------------------------------------------------------------------
  // Measurements taken at an edge. The "+1" accounts for the clock/line on
  // which the edge itself is seen; a saturated counter stays clamped rather
  // than wrapping to 0.
  // -------------------------------------------------------------------------
  logic          h_sat;
  logic          v_sat;
  logic [HW-1:0] m_line;
  logic [VW-1:0] m_frame;

  assign h_sat   = (h_pos == H_MAX);
  assign v_sat   = (v_pos == V_MAX);
  assign m_line  = h_sat ? H_MAX : h_pos + H_ONE;
  assign m_frame = v_sat ? V_MAX : v_pos + V_ONE;

  // -------------------------------------------------------------------------
  // Position counters, measurements and sync width counters
  // -------------------------------------------------------------------------
  logic [HW-1:0] hs_cnt_reg;
  logic [VW-1:0] vs_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      h_pos       <= '0;
      v_pos       <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      hs_cnt_reg  <= '0;
      vs_cnt_reg  <= '0;
      hs_width    <= '0;
      vs_width    <= '0;
    end else begin
      hs_d        <= hs_s;
      vs_d        <= vs_s;
      frame_start <= vs_rise;

      if (hs_rise) begin
        h_pos    <= '0;
        line_len <= m_line;
      end else if (!h_sat) begin
        h_pos <= h_pos + H_ONE;
      end

      if (vs_rise) begin
        v_pos       <= '0;
        frame_lines <= m_frame;
      end else if (hs_rise && !v_sat) begin
        v_pos <= v_pos + V_ONE;
      end

      // hsync width in clocks: the rising sample counts as the first clock.
      if (hs_rise) begin
        hs_cnt_reg <= H_ONE;
      end else if (hs_s && hs_cnt_reg != H_MAX) begin
        hs_cnt_reg <= hs_cnt_reg + H_ONE;
      end
      if (hs_fall) begin
        hs_width <= hs_cnt_reg;
      end

      // vsync width in lines: the line that starts with the vsync rise is
      // included; a line starting on the same clock vsync falls is not.
      if (vs_rise) begin
        vs_cnt_reg <= hs_rise ? V_ONE : '0;
      end else if (vs_s && hs_rise && vs_cnt_reg != V_MAX) begin
        vs_cnt_reg <= vs_cnt_reg + V_ONE;
      end
      if (vs_fall) begin
        vs_width <= vs_cnt_reg;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  state_t        state_reg,     state_next;
  logic [HW-1:0] ref_line_reg,  ref_line_next;
  logic [VW-1:0] ref_frame_reg, ref_frame_next;
  logic [MW-1:0] match_cnt_reg, match_cnt_next;
  logic          frame_bad_reg, frame_bad_next;
  logic          line_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SEARCH;
      ref_line_reg  <= '0;
      ref_frame_reg <= '0;
      match_cnt_reg <= '0;
      frame_bad_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ref_line_reg  <= ref_line_next;
      ref_frame_reg <= ref_frame_next;
      match_cnt_reg <= match_cnt_next;
      frame_bad_reg <= frame_bad_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ref_line_next  = ref_line_reg;
    ref_frame_next = ref_frame_reg;
    match_cnt_next = match_cnt_reg;
    frame_bad_next = frame_bad_reg;
    err            = 1'b0;

    // The line that closes a frame is judged with the same measurement used
    // for the frame decision, so a bad last line cannot slip through and a
    // combined line+frame fault still yields only one err pulse.
    line_bad = hs_rise && (m_line != ref_line_reg);

    case (state_reg)
      SEARCH: begin
        if (vs_rise) begin
          state_next = MEASURE;
        end
      end

      MEASURE: begin
        // The first vsync may arrive mid-frame, so only lines and the frame
        // seen after it are trusted as references.
        if (hs_rise) begin
          ref_line_next = m_line;
        end
        if (vs_rise) begin
          ref_frame_next = m_frame;
          match_cnt_next = '0;
          frame_bad_next = 1'b0;
          state_next     = CHECK;
        end
      end

      CHECK: begin
        if (vs_rise) begin
          if (!frame_bad_reg && !line_bad && m_frame == ref_frame_reg) begin
            match_cnt_next = match_cnt_reg + M_ONE;
            if (match_cnt_next >= LOCK_CNT) begin
              state_next = LOCKED;
            end
          end else begin
            // Restart the comparison from the frame just seen.
            err            = 1'b1;
            if (hs_rise) begin
              ref_line_next = m_line;
            end
            ref_frame_next = m_frame;
            match_cnt_next = '0;
            frame_bad_next = 1'b0;
          end
        end else if (line_bad) begin
          frame_bad_next = 1'b1;
        end
      end

      LOCKED: begin
        // A saturated position means an edge went missing; treat it as a
        // violation so position outputs are never trusted while clamped.
        if (line_bad || (vs_rise && m_frame != ref_frame_reg) || h_sat || v_sat) begin
          err        = 1'b1;
          state_next = SEARCH;
        end
      end

      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign locked = (state_reg == LOCKED);

  assign de = locked &&
              (h_pos >= H_DE_LO) && (h_pos <= H_DE_HI) &&
              (v_pos >= V_DE_LO) && (v_pos <= V_DE_HI);

endmodule
